stream_xbar_fifo: RTL and testbench

- Parametrised successor to the packet stream crossbar: S_DATA_COUNT slave ports route whole packets to M_DATA_COUNT master ports by s_dest_i.
- Each master port has a per-output round-robin arbiter with a packet lock, followed by a FIFO of depth FIFO_DEPTH.
- Congestion on one output no longer stalls the source until that output's FIFO fills.
- Sits between stream producers (DMA, packetisers) and consumers inside the stream fabric.

---
 rtl/stream_xbar_fifo_if.sv | 31 +++
 rtl/stream_xbar_fifo.sv | 181 ++++++++++++++++++
 tb/tb_stream_xbar_fifo.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_xbar_fifo_if.sv
// Port bundle for stream_xbar_fifo: slave-side beat inputs and master-side beat outputs.
// The crossbar takes the slave modport; whatever drives and consumes the crossbar takes the master modport.
interface stream_xbar_fifo_if #(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_DATA_COUNT = 4,
  parameter int M_DATA_COUNT = 4
);
  localparam int DEST_W = (M_DATA_COUNT > 1) ? $clog2(M_DATA_COUNT) : 1;
  localparam int ID_W   = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1;

  logic [S_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] s_data_i;
  logic [S_DATA_COUNT-1:0][DEST_W-1:0]       s_dest_i;
  logic [S_DATA_COUNT-1:0]                   s_last_i;
  logic [S_DATA_COUNT-1:0]                   s_valid_i;
  logic [S_DATA_COUNT-1:0]                   s_ready_o;
  logic [M_DATA_COUNT-1:0][T_DATA_WIDTH-1:0] m_data_o;
  logic [M_DATA_COUNT-1:0][ID_W-1:0]         m_id_o;
  logic [M_DATA_COUNT-1:0]                   m_last_o;
  logic [M_DATA_COUNT-1:0]                   m_valid_o;
  logic [M_DATA_COUNT-1:0]                   m_ready_i;

  modport slave (
    input  s_data_i, s_dest_i, s_last_i, s_valid_i, m_ready_i,
    output s_ready_o, m_data_o, m_id_o, m_last_o, m_valid_o
  );

  modport master (
    output s_data_i, s_dest_i, s_last_i, s_valid_i, m_ready_i,
    input  s_ready_o, m_data_o, m_id_o, m_last_o, m_valid_o
  );
endinterface

// File: rtl/stream_xbar_fifo.sv
// Packet crossbar: per-output round-robin arbiter with packet lock feeding a per-output FIFO.
// Optional STREAM_XBAR_FIFO_BAD_DEST_DROP_EN: swallow packets whose first-beat dest is out of range.
module stream_xbar_fifo #(
  parameter int T_DATA_WIDTH = 8,
  parameter int S_DATA_COUNT = 4,
  parameter int M_DATA_COUNT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef STREAM_XBAR_FIFO_BAD_DEST_DROP_EN
  output logic [S_DATA_COUNT-1:0] bad_dest_o,
`endif
  stream_xbar_fifo_if.slave       bus
);
  localparam int ID_W = (S_DATA_COUNT > 1) ? $clog2(S_DATA_COUNT) : 1;
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int EW   = T_DATA_WIDTH + ID_W + 1;

  typedef enum logic {ST_IDLE, ST_LOCKED} arb_state_t;

  arb_state_t      r_state     [M_DATA_COUNT];
  arb_state_t      w_state_nxt [M_DATA_COUNT];
  logic [ID_W-1:0] r_owner     [M_DATA_COUNT];
  logic [ID_W-1:0] w_owner_nxt [M_DATA_COUNT];
  logic [ID_W-1:0] r_rr        [M_DATA_COUNT];
  logic [ID_W-1:0] w_rr_nxt    [M_DATA_COUNT];
  logic [ID_W-1:0] w_gnt_src   [M_DATA_COUNT];
  logic [AW:0]     r_wptr      [M_DATA_COUNT];
  logic [AW:0]     r_rptr      [M_DATA_COUNT];
  logic [EW-1:0]   r_mem       [M_DATA_COUNT][FIFO_DEPTH];

  logic                                     r_run;
  logic [S_DATA_COUNT-1:0]                  w_locked;
  logic [S_DATA_COUNT-1:0]                  w_s_ready;
  logic [M_DATA_COUNT-1:0][S_DATA_COUNT-1:0] w_req;
  logic [M_DATA_COUNT-1:0]                  w_gnt_vld;
  logic [M_DATA_COUNT-1:0]                  w_push;
  logic [M_DATA_COUNT-1:0]                  w_pop;
  logic [M_DATA_COUNT-1:0]                  w_full;
  logic [M_DATA_COUNT-1:0]                  w_empty;

  function automatic logic [ID_W-1:0] next_src(input logic [ID_W-1:0] src);
    return (32'(src) == 32'(S_DATA_COUNT - 1)) ? '0 : ID_W'(32'(src) + 32'd1);
  endfunction

  function automatic logic [ID_W-1:0] rr_idx(input logic [ID_W-1:0] ptr, input int unsigned k);
    return ID_W'((32'(ptr) + k) % 32'(S_DATA_COUNT));
  endfunction

`ifdef STREAM_XBAR_FIFO_BAD_DEST_DROP_EN
  logic [S_DATA_COUNT-1:0] r_drop;
  logic [S_DATA_COUNT-1:0] w_bad_start;
  logic [S_DATA_COUNT-1:0] w_arb_locked;

  always_comb begin
    w_arb_locked = '0;
    for (int unsigned o = 0; o < M_DATA_COUNT; o++)
      if (r_state[o] == ST_LOCKED) w_arb_locked[r_owner[o]] = 1'b1;
    for (int unsigned i = 0; i < S_DATA_COUNT; i++)
      w_bad_start[i] = r_run && bus.s_valid_i[i] && !r_drop[i] && !w_arb_locked[i] &&
                       (32'(bus.s_dest_i[i]) >= 32'(M_DATA_COUNT));
    w_locked = w_arb_locked | r_drop;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_drop     <= '0;
      bad_dest_o <= '0;
    end else begin
      for (int unsigned i = 0; i < S_DATA_COUNT; i++) begin
        if (w_bad_start[i]) begin
          bad_dest_o[i] <= 1'b1;
          r_drop[i]     <= !bus.s_last_i[i];
        end else if (r_drop[i] && bus.s_valid_i[i] && bus.s_last_i[i]) begin
          r_drop[i] <= 1'b0;
        end
      end
    end
  end
`else
  always_comb begin
    w_locked = '0;
    for (int unsigned o = 0; o < M_DATA_COUNT; o++)
      if (r_state[o] == ST_LOCKED) w_locked[r_owner[o]] = 1'b1;
  end
`endif

  // A source whose dest matches no output never raises a request, so it simply waits.
  always_comb begin
    for (int unsigned o = 0; o < M_DATA_COUNT; o++) begin
      for (int unsigned i = 0; i < S_DATA_COUNT; i++)
        w_req[o][i] = bus.s_valid_i[i] && !w_locked[i] && (32'(bus.s_dest_i[i]) == o);
      w_gnt_vld[o] = 1'b0;
      w_gnt_src[o] = '0;
      if (r_state[o] == ST_LOCKED) begin
        w_gnt_vld[o] = 1'b1;
        w_gnt_src[o] = r_owner[o];
      end else begin
        for (int unsigned k = 0; k < S_DATA_COUNT; k++) begin
          if (!w_gnt_vld[o] && w_req[o][rr_idx(r_rr[o], k)]) begin
            w_gnt_vld[o] = 1'b1;
            w_gnt_src[o] = rr_idx(r_rr[o], k);
          end
        end
      end
    end
  end

  always_comb begin
    w_s_ready = '0;
    for (int unsigned o = 0; o < M_DATA_COUNT; o++) begin
      w_push[o] = r_run && w_gnt_vld[o] && !w_full[o] && bus.s_valid_i[w_gnt_src[o]];
      if (r_run && w_gnt_vld[o] && !w_full[o]) w_s_ready[w_gnt_src[o]] = 1'b1;
    end
`ifdef STREAM_XBAR_FIFO_BAD_DEST_DROP_EN
    w_s_ready = w_s_ready | r_drop | w_bad_start;
`endif
  end

  assign bus.s_ready_o = w_s_ready;

  always_comb begin
    for (int unsigned o = 0; o < M_DATA_COUNT; o++) begin
      w_state_nxt[o] = r_state[o];
      w_owner_nxt[o] = r_owner[o];
      w_rr_nxt[o]    = r_rr[o];
      if (w_push[o]) begin
        if (bus.s_last_i[w_gnt_src[o]]) begin
          w_state_nxt[o] = ST_IDLE;
          w_rr_nxt[o]    = next_src(w_gnt_src[o]);
        end else begin
          w_state_nxt[o] = ST_LOCKED;
          w_owner_nxt[o] = w_gnt_src[o];
        end
      end
    end
  end

  // r_run holds sources off until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_run <= 1'b0;
      for (int unsigned o = 0; o < M_DATA_COUNT; o++) begin
        r_state[o] <= ST_IDLE;
        r_owner[o] <= '0;
        r_rr[o]    <= '0;
        r_wptr[o]  <= '0;
        r_rptr[o]  <= '0;
      end
    end else begin
      r_run <= 1'b1;
      for (int unsigned o = 0; o < M_DATA_COUNT; o++) begin
        r_state[o] <= w_state_nxt[o];
        r_owner[o] <= w_owner_nxt[o];
        r_rr[o]    <= w_rr_nxt[o];
        if (w_push[o]) r_wptr[o] <= r_wptr[o] + (AW+1)'(1);
        if (w_pop[o])  r_rptr[o] <= r_rptr[o] + (AW+1)'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int unsigned o = 0; o < M_DATA_COUNT; o++)
      if (w_push[o])
        r_mem[o][r_wptr[o][AW-1:0]] <= {bus.s_data_i[w_gnt_src[o]], w_gnt_src[o],
                                        bus.s_last_i[w_gnt_src[o]]};
  end

  always_comb begin
    for (int unsigned o = 0; o < M_DATA_COUNT; o++) begin
      w_empty[o] = (r_wptr[o] == r_rptr[o]);
      w_full[o]  = (r_wptr[o][AW] != r_rptr[o][AW]) &&
                   (r_wptr[o][AW-1:0] == r_rptr[o][AW-1:0]);
      w_pop[o]   = !w_empty[o] && bus.m_ready_i[o];
      bus.m_valid_o[o] = !w_empty[o];
      {bus.m_data_o[o], bus.m_id_o[o], bus.m_last_o[o]} =
        w_empty[o] ? '0 : r_mem[o][r_rptr[o][AW-1:0]];
    end
  end
endmodule

// File: tb/tb_stream_xbar_fifo.sv
// Bench for stream_xbar_fifo (S=2, M=2, W=4, DEPTH=4): directed plus random packets vs a packet-level model.
`timescale 1ns/1ps
module tb_stream_xbar_fifo;
  localparam int W = 4;
  localparam int S = 2;
  localparam int M = 2;
  localparam int D = 4;

  typedef struct packed { logic [W-1:0] d; logic id;   logic last; } beat_t;
  typedef struct packed { logic [W-1:0] d; logic dest; logic last; } stim_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  stream_xbar_fifo_if #(.T_DATA_WIDTH(W), .S_DATA_COUNT(S), .M_DATA_COUNT(M)) bus ();
  stream_xbar_fifo_if #(.T_DATA_WIDTH(W), .S_DATA_COUNT(S), .M_DATA_COUNT(3)) bus3 ();

`ifdef STREAM_XBAR_FIFO_BAD_DEST_DROP_EN
  logic [S-1:0] bad_main, bad3;
`endif

  stream_xbar_fifo #(.T_DATA_WIDTH(W), .S_DATA_COUNT(S), .M_DATA_COUNT(M), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
`ifdef STREAM_XBAR_FIFO_BAD_DEST_DROP_EN
    .bad_dest_o(bad_main),
`endif
    .bus(bus));

  // Three outputs give a 2-bit dest, so dest 3 is out of range.
  stream_xbar_fifo #(.T_DATA_WIDTH(W), .S_DATA_COUNT(S), .M_DATA_COUNT(3), .FIFO_DEPTH(D)) dut3 (
    .clk(clk), .rst_n(rst_n),
`ifdef STREAM_XBAR_FIFO_BAD_DEST_DROP_EN
    .bad_dest_o(bad3),
`endif
    .bus(bus3));

  int n_checks = 0, n_pass = 0, n_fail = 0, cyc = 0;
  stim_t stim [S][$];
  beat_t mq   [M][$];
  beat_t olog [M][$];
  int    ocyc [M][$];
  bit    in_pkt [S];
  int    pdest  [S];
  int    owner  [M];
  int    stall  [S];
  int    oor_ready = 0, oor_samples = 0;
  logic [M-1:0] mr_fixed = '1;
  bit    rand_ready = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int src, input logic [W-1:0] d, input logic dest, input logic last);
    stim_t s;
    s = {d, dest, last};
    stim[src].push_back(s);
  endtask

  task automatic clear_logs();
    for (int o = 0; o < M; o++) begin olog[o].delete(); ocyc[o].delete(); end
    for (int i = 0; i < S; i++) stall[i] = 0;
  endtask

  function automatic bit busy();
    return (stim[0].size() != 0) || (stim[1].size() != 0) || (mq[0].size() != 0) || (mq[1].size() != 0);
  endfunction

  task automatic present();
    for (int i = 0; i < S; i++) begin
      if (stim[i].size() != 0) begin
        bus.s_valid_i[i] = 1'b1;
        bus.s_data_i[i]  = stim[i][0].d;
        bus.s_dest_i[i]  = stim[i][0].dest;
        bus.s_last_i[i]  = stim[i][0].last;
      end else begin
        bus.s_valid_i[i] = 1'b0;
      end
    end
    bus.m_ready_i = rand_ready ? 2'($urandom) : mr_fixed;
  endtask

  // Model: a beat reaches an output queue when accepted; its output is fixed by the packet's first beat.
  task automatic sample();
    beat_t b;
    bit    pop [M];
    int    d;
    for (int o = 0; o < M; o++) begin
      pop[o] = 1'b0;
      chk($sformatf("m_valid[%0d]", o), 32'(bus.m_valid_o[o]), 32'(mq[o].size() != 0));
      if (bus.m_valid_o[o] && mq[o].size() != 0) begin
        b = mq[o][0];
        chk($sformatf("m_data[%0d]", o), 32'(bus.m_data_o[o]), 32'(b.d));
        chk($sformatf("m_id[%0d]", o),   32'(bus.m_id_o[o]),   32'(b.id));
        chk($sformatf("m_last[%0d]", o), 32'(bus.m_last_o[o]), 32'(b.last));
        if (bus.m_ready_i[o]) begin
          pop[o] = 1'b1;
          b = {bus.m_data_o[o], bus.m_id_o[o], bus.m_last_o[o]};
          olog[o].push_back(b);
          ocyc[o].push_back(cyc);
        end
      end
    end
    for (int i = 0; i < S; i++) begin
      if (bus.s_valid_i[i] && !bus.s_ready_o[i]) stall[i]++;
      if (bus.s_valid_i[i] && bus.s_ready_o[i]) begin
        if (!in_pkt[i]) pdest[i] = int'(bus.s_dest_i[i]);
        d = pdest[i];
        if (owner[d] >= 0) chk($sformatf("pkt_lock[%0d]", d), 32'(i), 32'(owner[d]));
        chk($sformatf("push_not_full[%0d]", d), 32'(mq[d].size() < D), 32'd1);
        b = {bus.s_data_i[i], 1'(i), bus.s_last_i[i]};
        mq[d].push_back(b);
        owner[d]  = bus.s_last_i[i] ? -1 : i;
        in_pkt[i] = !bus.s_last_i[i];
        void'(stim[i].pop_front());
      end
    end
    for (int o = 0; o < M; o++) if (pop[o]) void'(mq[o].pop_front());
    oor_samples++;
    oor_ready += int'(bus3.s_ready_o[0]);
  endtask

  task automatic step();
    present();
    @(negedge clk);
    sample();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_n(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic drain(input int budget, input string tag);
    int n;
    n = 0;
    while (busy() && n < budget) begin step(); n++; end
    chk({tag, "_done"}, 32'(busy()), 32'd0);
  endtask

  task automatic chk_log(input string tag, input int o, input int k, input beat_t exp, input int exp_cyc);
    if (k < olog[o].size()) begin
      chk({tag, "_beat"}, 32'(olog[o][k]), 32'(exp));
      if (exp_cyc >= 0) chk({tag, "_cyc"}, 32'(ocyc[o][k]), 32'(exp_cyc));
    end
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int t0, nb, len, src;
    logic [W-1:0] bp [6];
    logic [W-1:0] x0, x1;
    logic dst;

    for (int o = 0; o < M; o++) owner[o] = -1;
    for (int i = 0; i < S; i++) begin in_pkt[i] = 1'b0; pdest[i] = 0; stall[i] = 0; end
    bus.s_valid_i = 2'b01; bus.s_data_i = '0; bus.s_dest_i = '0; bus.s_last_i = '0;
    bus.m_ready_i = '1;
    bus3.s_valid_i = 2'b01; bus3.s_data_i = '0; bus3.s_last_i = '0; bus3.m_ready_i = '1;
    bus3.s_dest_i[0] = 2'd3; bus3.s_dest_i[1] = 2'd0;

    // Reset state: outputs quiet and no source accepted even while one is valid.
    #12;
    chk("rst_m_valid", 32'(bus.m_valid_o), 32'd0);
    chk("rst_m_data",  32'(bus.m_data_o),  32'd0);
    chk("rst_m_id",    32'(bus.m_id_o),    32'd0);
    chk("rst_m_last",  32'(bus.m_last_o),  32'd0);
    chk("rst_s_ready", 32'(bus.s_ready_o), 32'd0);
    bus.s_valid_i = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Contention: both sources to output 0 from the same cycle.
    clear_logs();
    push(0, 4'hA, 1'b0, 1'b0); push(0, 4'hB, 1'b0, 1'b1);
    push(1, 4'hC, 1'b0, 1'b0); push(1, 4'hD, 1'b0, 1'b1);
    t0 = cyc;
    drain(20, "contention");
    chk("cont_count", 32'(olog[0].size()), 32'd4);
    chk_log("cont0", 0, 0, {4'hA, 1'b0, 1'b0}, t0 + 1);
    chk_log("cont1", 0, 1, {4'hB, 1'b0, 1'b1}, t0 + 2);
    chk_log("cont2", 0, 2, {4'hC, 1'b1, 1'b0}, t0 + 3);
    chk_log("cont3", 0, 3, {4'hD, 1'b1, 1'b1}, t0 + 4);

    // Round-robin: single-beat packets from both sources alternate ids.
    clear_logs();
    for (int k = 0; k < 4; k++) begin
      push(0, 4'($urandom), 1'b0, 1'b1);
      push(1, 4'($urandom), 1'b0, 1'b1);
    end
    drain(30, "rr");
    chk("rr_count", 32'(olog[0].size()), 32'd8);
    for (int k = 0; k < 8; k++)
      if (k < olog[0].size()) chk($sformatf("rr_id%0d", k), 32'(olog[0][k].id), 32'(k % 2));

    // Parallel routing: crossing packets never stall and emit side by side.
    clear_logs();
    push(0, 4'hE, 1'b1, 1'b0); push(0, 4'hF, 1'b1, 1'b1);
    push(1, 4'h8, 1'b0, 1'b0); push(1, 4'h9, 1'b0, 1'b1);
    t0 = cyc;
    drain(20, "par");
    chk_log("par_m1_0", 1, 0, {4'hE, 1'b0, 1'b0}, t0 + 1);
    chk_log("par_m1_1", 1, 1, {4'hF, 1'b0, 1'b1}, t0 + 2);
    chk_log("par_m0_0", 0, 0, {4'h8, 1'b1, 1'b0}, t0 + 1);
    chk_log("par_m0_1", 0, 1, {4'h9, 1'b1, 1'b1}, t0 + 2);
    chk("par_no_stall", 32'(stall[0] + stall[1]), 32'd0);

    // Backpressure: output 0 stalled, a 6-beat packet fills its FIFO after 4 beats.
    clear_logs();
    mr_fixed = 2'b10;
    for (int k = 0; k < 6; k++) begin
      bp[k] = 4'($urandom);
      push(0, bp[k], 1'b0, 1'(k == 5));
    end
    run_n(7);
    chk("bp_accepted", 32'(mq[0].size()), 32'd4);
    chk("bp_ready_low", 32'(bus.s_ready_o[0]), 32'd0);
    chk("bp_head_held", 32'(bus.m_data_o[0]), 32'(bp[0]));

    // Isolation: output 1 keeps flowing while output 0 is full and stalled.
    x0 = 4'($urandom); x1 = 4'($urandom);
    push(1, x0, 1'b1, 1'b0); push(1, x1, 1'b1, 1'b1);
    t0 = cyc;
    run_n(4);
    chk("iso_count", 32'(olog[1].size()), 32'd2);
    chk("iso_no_stall", 32'(stall[1]), 32'd0);
    chk_log("iso0", 1, 0, {x0, 1'b1, 1'b0}, t0 + 1);
    chk_log("iso1", 1, 1, {x1, 1'b1, 1'b1}, t0 + 2);

    mr_fixed = '1;
    drain(30, "bp");
    chk("bp_count", 32'(olog[0].size()), 32'd6);
    for (int k = 0; k < 6; k++) chk_log($sformatf("bp%0d", k), 0, k, {bp[k], 1'b0, 1'(k == 5)}, -1);

    // Random packets, random mid-packet dest, random output readiness.
    clear_logs();
    rand_ready = 1'b1;
    nb = 0;
    for (int p = 0; p < 40; p++) begin
      src = int'($urandom_range(0, 1));
      len = int'($urandom_range(1, 3));
      dst = 1'($urandom);
      for (int k = 0; k < len; k++) begin
        push(src, 4'($urandom), (k == 0) ? dst : 1'($urandom), 1'(k == len - 1));
        nb++;
      end
    end
    drain(2000, "random");
    chk("rand_count", 32'(olog[0].size() + olog[1].size()), 32'(nb));
    rand_ready = 1'b0;
    mr_fixed = '1;

    // Reset mid-packet: beat 1 of 3 lands, then reset clears it and the lock.
    clear_logs();
    push(0, 4'h1, 1'b1, 1'b0); push(0, 4'h2, 1'b1, 1'b0); push(0, 4'h3, 1'b1, 1'b1);
    step();
    chk("pre_rst_valid", 32'(bus.m_valid_o[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_m_valid", 32'(bus.m_valid_o), 32'd0);
    chk("mid_rst_s_ready", 32'(bus.s_ready_o), 32'd0);
    for (int i = 0; i < S; i++) begin stim[i].delete(); in_pkt[i] = 1'b0; end
    for (int o = 0; o < M; o++) begin mq[o].delete(); owner[o] = -1; end
    bus.s_valid_i = '0;
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    cyc++;
    clear_logs();
    x0 = 4'($urandom); x1 = 4'($urandom);
    push(1, x0, 1'b1, 1'b0); push(1, x1, 1'b1, 1'b1);
    t0 = cyc;
    drain(20, "post_rst");
    chk("post_rst_count", 32'(olog[1].size()), 32'd2);
    chk_log("post_rst0", 1, 0, {x0, 1'b1, 1'b0}, t0 + 1);
    chk_log("post_rst1", 1, 1, {x1, 1'b1, 1'b1}, t0 + 2);

    // Out-of-range dest on the three-output instance.
`ifdef STREAM_XBAR_FIFO_BAD_DEST_DROP_EN
    chk("oor_ready", 32'(oor_ready), 32'(oor_samples));
    chk("oor_bad_dest", 32'(bad3[0]), 32'd1);
`else
    chk("oor_ready", 32'(oor_ready), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
